// File: rtl/sift_pkg.sv
// Shared constants, types and helpers for the SIFT scale-space pipeline.
package sift_pkg;

  localparam int unsigned SIFT_COLS   = 640;
  localparam int unsigned SIFT_ROWS   = 480;
  localparam int unsigned SIFT_THRESH = 8;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned DOG_W       = PIX_W + 1;
  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;

  typedef logic signed [DOG_W-1:0] dog_t;

  // Returns {centre > neighbour, centre < neighbour}; both low on a tie.
  function automatic logic [1:0] dog_cmp(input dog_t centre, input dog_t nbr);
    dog_cmp = {(centre > nbr), (centre < nbr)};
  endfunction

endpackage

// File: rtl/dog_extrema_detect_if.sv
// Pixel-pair input stream and keypoint-candidate result stream of the DoG extrema stage.
interface dog_extrema_detect_if;
  import sift_pkg::*;

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_blur_a;
  logic [PIX_W-1:0] in_blur_b;
  logic             out_valid;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  dog_t             out_dog;
  logic             out_kpt;
  logic             out_is_max;

  modport master (
    output in_valid, in_sof, in_blur_a, in_blur_b,
    input  out_valid, out_x, out_y, out_dog, out_kpt, out_is_max
  );

  modport slave (
    input  in_valid, in_sof, in_blur_a, in_blur_b,
    output out_valid, out_x, out_y, out_dog, out_kpt, out_is_max
  );

endinterface

// File: rtl/dog_line_buffer.sv
// One line of DoG samples; single address port, read returns the value stored before this write.
module dog_line_buffer #(
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Contents are never cleared; rows are only trusted once refilled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/dog_extrema_detect.sv
// Forms DoG from two blur scales, scans a 3x3 DoG window and flags strict local extrema
// whose magnitude reaches THRESH as keypoint candidates.
module dog_extrema_detect #(
  parameter int unsigned COLS   = sift_pkg::SIFT_COLS,
  parameter int unsigned ROWS   = sift_pkg::SIFT_ROWS,
  parameter int unsigned THRESH = sift_pkg::SIFT_THRESH
) (
  input logic                 clk,
  input logic                 rst_n,
  dog_extrema_detect_if.slave bus
);
  import sift_pkg::*;

  localparam int unsigned AW = $clog2(COLS);
  localparam dog_t THR_POS = DOG_W'(THRESH);
  localparam dog_t THR_NEG = -THR_POS;

  logic           accept_s;
  logic           complete_s;
  logic [X_W-1:0] col_r, pos_col_s, nxt_col_s;
  logic [Y_W-1:0] row_r, pos_row_s, nxt_row_s;
  dog_t           dog_s, lb0_rd_s, lb1_rd_s;
  dog_t           win_r [3][3];
  logic [1:0]     cmp_s;
  logic           gt_all_s, lt_all_s, kpt_s;
  logic           v1_r, v2_r, v3_r;
  logic [X_W-1:0] x1_r, x2_r, x3_r;
  logic [Y_W-1:0] y1_r, y2_r, y3_r;
  dog_t           c2_r, c3_r;
  logic           gt_all_r, lt_all_r, kpt3_r, max3_r;

  assign accept_s = bus.in_valid;
  assign dog_s    = $signed({1'b0, bus.in_blur_a}) - $signed({1'b0, bus.in_blur_b});

  // Position of the pixel being presented, its successor and whether it completes a window.
  always_comb begin
    pos_col_s = col_r;
    pos_row_s = row_r;
    if (bus.in_sof) begin
      pos_col_s = X_W'(0);
      pos_row_s = Y_W'(0);
    end else begin
      pos_col_s = col_r;
    end
    nxt_col_s = pos_col_s + X_W'(1);
    nxt_row_s = pos_row_s;
    if (pos_col_s == X_W'(COLS - 1)) begin
      nxt_col_s = X_W'(0);
      if (pos_row_s == Y_W'(ROWS - 1)) begin
        nxt_row_s = Y_W'(0);
      end else begin
        nxt_row_s = pos_row_s + Y_W'(1);
      end
    end else begin
      nxt_row_s = pos_row_s;
    end
    complete_s = (pos_col_s >= X_W'(2)) && (pos_row_s >= Y_W'(2));
  end

  // Raster position counters advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= X_W'(0);
      row_r <= Y_W'(0);
    end else if (accept_s) begin
      col_r <= nxt_col_s;
      row_r <= nxt_row_s;
    end
  end

  // lb0 holds the previous line, lb1 the line before it; lb0's old value cascades into lb1.
  dog_line_buffer #(.DEPTH(COLS), .WIDTH(DOG_W), .ADDR_W(AW)) u_lb0 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (pos_col_s[AW-1:0]),
    .wdata (dog_s),
    .rdata (lb0_rd_s)
  );

  dog_line_buffer #(.DEPTH(COLS), .WIDTH(DOG_W), .ADDR_W(AW)) u_lb1 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (pos_col_s[AW-1:0]),
    .wdata (lb0_rd_s),
    .rdata (lb1_rd_s)
  );

  // Window row 0 is two lines up, row 2 the current line; column 2 is the newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_r[r][c] <= DOG_W'(0);
        end
      end
    end else if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_r[r][1];
        win_r[r][1] <= win_r[r][2];
      end
      win_r[0][2] <= lb1_rd_s;
      win_r[1][2] <= lb0_rd_s;
      win_r[2][2] <= dog_s;
    end
  end

  // Stage 1 token: the window just completed, tagged with its centre coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      x1_r <= X_W'(0);
      y1_r <= Y_W'(0);
    end else begin
      v1_r <= accept_s & complete_s;
      if (accept_s) begin
        x1_r <= pos_col_s - X_W'(1);
        y1_r <= pos_row_s - Y_W'(1);
      end
    end
  end

  // Centre against its eight neighbours; any tie clears both strict flags.
  always_comb begin
    gt_all_s = 1'b1;
    lt_all_s = 1'b1;
    cmp_s    = 2'b00;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r != 1) || (c != 1)) begin
          cmp_s    = dog_cmp(win_r[1][1], win_r[r][c]);
          gt_all_s = gt_all_s & cmp_s[1];
          lt_all_s = lt_all_s & cmp_s[0];
        end else begin
          cmp_s = 2'b00;
        end
      end
    end
  end

  // Stage 2: comparator results. The pipeline drains every cycle, independent of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r     <= 1'b0;
      gt_all_r <= 1'b0;
      lt_all_r <= 1'b0;
      c2_r     <= DOG_W'(0);
      x2_r     <= X_W'(0);
      y2_r     <= Y_W'(0);
    end else begin
      v2_r     <= v1_r;
      gt_all_r <= gt_all_s;
      lt_all_r <= lt_all_s;
      c2_r     <= win_r[1][1];
      x2_r     <= x1_r;
      y2_r     <= y1_r;
    end
  end

  assign kpt_s = (gt_all_r && (c2_r >= THR_POS)) || (lt_all_r && (c2_r <= THR_NEG));

  // Stage 3: threshold qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r   <= 1'b0;
      kpt3_r <= 1'b0;
      max3_r <= 1'b0;
      c3_r   <= DOG_W'(0);
      x3_r   <= X_W'(0);
      y3_r   <= Y_W'(0);
    end else begin
      v3_r   <= v2_r;
      kpt3_r <= v2_r & kpt_s;
      max3_r <= gt_all_r;
      c3_r   <= c2_r;
      x3_r   <= x2_r;
      y3_r   <= y2_r;
    end
  end

  // Registered result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_kpt    <= 1'b0;
      bus.out_is_max <= 1'b0;
      bus.out_dog    <= DOG_W'(0);
      bus.out_x      <= X_W'(0);
      bus.out_y      <= Y_W'(0);
    end else begin
      bus.out_valid  <= v3_r;
      bus.out_kpt    <= kpt3_r;
      bus.out_is_max <= kpt3_r & max3_r;
      bus.out_dog    <= c3_r;
      bus.out_x      <= x3_r;
      bus.out_y      <= y3_r;
    end
  end

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Self-checking bench for dog_extrema_detect on an 8x6 frame; a reference model
// computes every expected window result and its output cycle from the frame arrays.
module tb_dog_extrema_detect;
  import sift_pkg::*;

  localparam int C = 8;
  localparam int R = 6;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [DOG_W-1:0] dog;
    logic             kpt;
    logic             is_max;
    logic [31:0]      edge_n;
  } res_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof   = 1'b0;
  logic [7:0] a_t      = 8'd0;
  logic [7:0] b_t      = 8'd0;

  int   edge_cnt  = 0;
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   kpt11_cnt = 0;
  int   fa [R][C];
  int   fb [R][C];
  int   acc_edge [R][C];
  res_t obs_q [$];
  res_t exp_q [$];

  dog_extrema_detect_if bus5 ();
  dog_extrema_detect_if bus11 ();

  assign bus5.in_valid   = in_valid;
  assign bus5.in_sof     = in_sof;
  assign bus5.in_blur_a  = a_t;
  assign bus5.in_blur_b  = b_t;
  assign bus11.in_valid  = in_valid;
  assign bus11.in_sof    = in_sof;
  assign bus11.in_blur_a = a_t;
  assign bus11.in_blur_b = b_t;

  dog_extrema_detect #(.COLS(C), .ROWS(R), .THRESH(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  dog_extrema_detect #(.COLS(C), .ROWS(R), .THRESH(11)) dut11 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus11)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Results are sampled on the falling edge; is_max only matters for keypoints.
  always @(negedge clk) begin
    if (bus5.out_valid) begin
      obs_q.push_back('{bus5.out_x, bus5.out_y, bus5.out_dog, bus5.out_kpt,
                        bus5.out_is_max & bus5.out_kpt, 32'(edge_cnt)});
    end
    if (bus11.out_valid && bus11.out_kpt) kpt11_cnt++;
  end

  function automatic void set_flat();
    for (int y = 0; y < R; y++) begin
      for (int x = 0; x < C; x++) begin
        fa[y][x] = 100;
        fb[y][x] = 100;
      end
    end
  endfunction

  // Reference: every interior centre in raster order, strict-extremum and threshold rules.
  function automatic void build_expected(input int thr);
    exp_q.delete();
    for (int y = 1; y < R - 1; y++) begin
      for (int x = 1; x < C - 1; x++) begin
        int d;
        bit gt;
        bit lt;
        bit k;
        res_t e;
        d  = fa[y][x] - fb[y][x];
        gt = 1'b1;
        lt = 1'b1;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dy != 0 || dx != 0) begin
              int n;
              n = fa[y+dy][x+dx] - fb[y+dy][x+dx];
              if (d <= n) gt = 1'b0;
              if (d >= n) lt = 1'b0;
            end
          end
        end
        k = (gt && d >= thr) || (lt && d <= -thr);
        e.x      = X_W'(x);
        e.y      = Y_W'(y);
        e.dog    = DOG_W'(d);
        e.kpt    = k;
        e.is_max = k & gt;
        e.edge_n = 32'(acc_edge[y+1][x+1] + 3);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Drives the first n_pix pixels of the frame, with optional random bubbles.
  task automatic drive_frame(input int pct, input int n_pix);
    for (int p = 0; p < n_pix; p++) begin
      int y;
      int x;
      y = p / C;
      x = p % C;
      while (int'($urandom_range(99)) < pct) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_sof   = (p == 0);
      a_t      = 8'(fa[y][x]);
      b_t      = 8'(fb[y][x]);
      acc_edge[y][x] = edge_cnt + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus5.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %0b, required 0", bus5.out_valid);
    end
    n_cmp++;
    if ({bus5.out_x, bus5.out_y, bus5.out_dog} !== 28'd0) begin
      n_fail++; $display("FAIL reset_data: got x=%0d y=%0d dog=%0d, required 0", bus5.out_x, bus5.out_y, bus5.out_dog);
    end
    n_cmp++;
    if ({bus5.out_kpt, bus5.out_is_max} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got kpt=%0b max=%0b, required 0", bus5.out_kpt, bus5.out_is_max);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flat();
    set_flat();
    obs_q.delete();
    drive_frame(0, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    n_cmp++;
    if (obs_q.size() != 24) begin
      n_fail++; $display("FAIL flat_count: got %0d results, required 24", obs_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL flat_res[%0d]: got nothing, required %p", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL flat_res[%0d]: got %p, required %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic run_max_frame(input string tag, input int pct);
    int hits;
    set_flat();
    fa[2][3] = 110;
    obs_q.delete();
    kpt11_cnt = 0;
    drive_frame(pct, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d results, required %0d", tag, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL %s_res[%0d]: got nothing, required %p", tag, i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_res[%0d]: got %p, required %p", tag, i, obs_q[i], exp_q[i]);
      end
    end
    hits = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kpt) begin
        hits++;
        n_cmp++;
        if (obs_q[i].x !== 10'd3 || obs_q[i].y !== 9'd2 || obs_q[i].dog !== 9'd10 || obs_q[i].is_max !== 1'b1) begin
          n_fail++; $display("FAIL %s_kpt: got %p, required x=3 y=2 dog=10 max=1", tag, obs_q[i]);
        end
      end
    end
    n_cmp++;
    if (hits != 1) begin
      n_fail++; $display("FAIL %s_kpt_count: got %0d, required 1", tag, hits);
    end
    n_cmp++;
    if (kpt11_cnt != 0) begin
      n_fail++; $display("FAIL %s_thresh11: got %0d keypoints, required 0", tag, kpt11_cnt);
    end
  endtask

  task automatic test_max();
    run_max_frame("max", 0);
  endtask

  task automatic test_back_to_back_bubbles();
    run_max_frame("bubble", 30);
  endtask

  task automatic test_min();
    int hits;
    set_flat();
    fb[3][4] = 120;
    obs_q.delete();
    drive_frame(0, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL min_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL min_res[%0d]: got nothing, required %p", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL min_res[%0d]: got %p, required %p", i, obs_q[i], exp_q[i]);
      end
    end
    hits = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kpt) begin
        hits++;
        n_cmp++;
        if (obs_q[i].x !== 10'd4 || obs_q[i].y !== 9'd3 || obs_q[i].dog !== 9'h1EC || obs_q[i].is_max !== 1'b0) begin
          n_fail++; $display("FAIL min_kpt: got %p, required x=4 y=3 dog=-20 max=0", obs_q[i]);
        end
      end
    end
    n_cmp++;
    if (hits != 1) begin
      n_fail++; $display("FAIL min_kpt_count: got %0d, required 1", hits);
    end
  endtask

  task automatic test_tie();
    int hits;
    set_flat();
    fa[2][3] = 110;
    fa[2][4] = 110;
    obs_q.delete();
    drive_frame(0, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL tie_res[%0d]: got nothing, required %p", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL tie_res[%0d]: got %p, required %p", i, obs_q[i], exp_q[i]);
      end
    end
    hits = 0;
    foreach (obs_q[i]) hits += int'(obs_q[i].kpt);
    n_cmp++;
    if (hits != 0) begin
      n_fail++; $display("FAIL tie_kpt_count: got %0d, required 0", hits);
    end
  endtask

  task automatic test_sign_extremes();
    int seen;
    set_flat();
    fa[2][2] = 0;
    fb[2][2] = 255;
    fa[3][5] = 255;
    fb[3][5] = 0;
    obs_q.delete();
    drive_frame(0, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL sign_res[%0d]: got nothing, required %p", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sign_res[%0d]: got %p, required %p", i, obs_q[i], exp_q[i]);
      end
    end
    seen = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].x == 10'd2 && obs_q[i].y == 9'd2) begin
        seen++;
        n_cmp++;
        if (obs_q[i].dog !== 9'h101) begin
          n_fail++; $display("FAIL sign_neg: got dog=%0d, required -255", $signed(obs_q[i].dog));
        end
      end
      if (obs_q[i].x == 10'd5 && obs_q[i].y == 9'd3) begin
        seen++;
        n_cmp++;
        if (obs_q[i].dog !== 9'h0FF) begin
          n_fail++; $display("FAIL sign_pos: got dog=%0d, required 255", $signed(obs_q[i].dog));
        end
      end
    end
    n_cmp++;
    if (seen != 2) begin
      n_fail++; $display("FAIL sign_seen: got %0d extreme centres, required 2", seen);
    end
  endtask

  task automatic test_mid_reset();
    set_flat();
    fa[2][3] = 110;
    drive_frame(0, 20);
    rst_n = 1'b0;
    #1;
    obs_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus5.out_valid, bus5.out_kpt, bus5.out_is_max, bus5.out_x, bus5.out_y, bus5.out_dog} !== 31'd0) begin
        n_fail++; $display("FAIL midrst_out[%0d]: got valid=%0b kpt=%0b x=%0d y=%0d dog=%0d, required 0",
                           k, bus5.out_valid, bus5.out_kpt, bus5.out_x, bus5.out_y, bus5.out_dog);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    set_flat();
    drive_frame(0, R * C);
    repeat (8) @(negedge clk);
    build_expected(5);
    n_cmp++;
    if (obs_q.size() != 24) begin
      n_fail++; $display("FAIL midrst_count: got %0d results, required 24", obs_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs_q.size()) begin
        n_fail++; $display("FAIL midrst_res[%0d]: got nothing, required %p", i, exp_q[i]);
      end else if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midrst_res[%0d]: got %p, required %p", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_max();
    test_min();
    test_tie();
    test_sign_extremes();
    test_back_to_back_bubbles();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
